// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: default width,
// funct3 op encodings, sequencer states and the default counter width.
package mdu_pkg;

  localparam int MDU_XLEN  = 32;
  localparam int MDU_CNT_W = $clog2(MDU_XLEN);

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned datapath: shift-add multiply step or
// restoring shift-subtract divide step on the {hi,lo} working pair.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shl;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    w_shl  = {i_hi, i_lo[XLEN-1]};
    w_ge   = (w_shl >= {1'b0, i_b});
    // The partial remainder is below the divisor after subtraction, so XLEN bits suffice.
    w_diff = w_shl[XLEN-1:0] - i_b;
    if (i_is_div) begin
      o_hi = w_ge ? w_diff : w_shl[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit and its sequencing FSM (stalls EX while busy).
// Define MDU_DIV_EN to build the division datapath; otherwise div/rem return 0 via the fast path.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  mdu_state_e        r_state, w_next;
  mdu_op_e           r_op, w_op;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg, r_fast;
  logic [XLEN-1:0]   r_fast_res, r_hi, r_lo, r_b, r_result;
  logic              w_accept, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_fast, w_is_div;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_fast_res, w_step_hi, w_step_lo, w_fix_res;
  logic [2*XLEN-1:0] w_prod;

  assign w_op     = mdu_op_e'(op_i);
  assign w_accept = (r_state == IDLE) && start_i && !flush_i;
  assign w_a_sgn  = (w_op == MDU_MULH) || (w_op == MDU_MULHSU) || (w_op == MDU_DIV) || (w_op == MDU_REM);
  assign w_b_sgn  = (w_op == MDU_MULH) || (w_op == MDU_DIV) || (w_op == MDU_REM);
  assign w_a_neg  = w_a_sgn && rs1_i[XLEN-1];
  assign w_b_neg  = w_b_sgn && rs2_i[XLEN-1];
  assign w_a_mag  = cond_neg(rs1_i, w_a_neg);
  assign w_b_mag  = cond_neg(rs2_i, w_b_neg);

`ifdef MDU_DIV_EN
  logic w_div_zero, w_ovf;
  assign w_div_zero = (rs2_i == '0);
  assign w_ovf      = !op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign w_fast     = op_i[2] && (w_div_zero || w_ovf);
  assign w_is_div   = r_op[2];
  always_comb begin
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = op_i[1] ? rs1_i : '1;
    else if (w_ovf && !op_i[1])
      w_fast_res = rs1_i;
  end
`else
  assign w_fast     = op_i[2];
  assign w_fast_res = '0;
  assign w_is_div   = 1'b0;
`endif

  mdu_step #(.XLEN(XLEN)) u_step (
    .i_is_div (w_is_div),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_b      (r_b),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_fast ? FIX : CALC;
      CALC:    if (r_cnt == CNT_W'(XLEN-1)) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush_i) w_next = IDLE;
  end

  // DONE drops stall so the MDU instruction retires in the same cycle it completes.
  always_comb begin
    busy_o  = (r_state != IDLE);
    stall_o = ((r_state == IDLE) && start_i) || ((r_state != IDLE) && (r_state != DONE));
    done_o  = (r_state == DONE);
  end

  // Datapath works on magnitudes; multiplier/dividend sit in lo, multiplicand/divisor in b.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_op       <= MDU_MUL;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_res <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
    end else if (w_accept) begin
      r_op       <= w_op;
      r_cnt      <= '0;
      r_neg      <= (op_i[2] && op_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
      r_fast     <= w_fast;
      r_fast_res <= w_fast_res;
      r_hi       <= '0;
      r_lo       <= op_i[2] ? w_a_mag : w_b_mag;
      r_b        <= op_i[2] ? w_b_mag : w_a_mag;
    end else if (r_state == CALC) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_prod = cond_neg2({r_hi, r_lo}, r_neg);

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      MDU_MUL:                         w_fix_res = w_prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               w_fix_res = cond_neg(r_lo, r_neg);
      default:                         w_fix_res = cond_neg(r_hi, r_neg);
    endcase
    if (r_fast) w_fix_res = r_fast_res;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                          r_result <= '0;
    else if ((r_state == FIX) && !flush_i) r_result <= w_fix_res;
  end

  assign result_o = r_result;

endmodule
